core_mem_req_ctrl: RTL and testbench

//  Per-core memory request controller between a core's load/store stage and the 16 bank arbiters.

---
 rtl/core_mem_req_ctrl.sv | 126 ++++++++++++
 tb/tb_core_mem_req_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_req_ctrl.sv
// Per-core memory request controller.
// Takes one byte load/store from the core, holds the read/write strobe toward
// the bank arbiters until a finish comes back, and returns a one-cycle
// response. A watchdog aborts requests that never see a finish.
module core_mem_req_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_finish,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stray_fin
);

  // One-hot pair so that any corrupted encoding is distinguishable and
  // steered back to IDLE by the default branch.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    REQ  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                in_req;
  logic                accept;
  logic                done;
  logic                tmo;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus strobes; strobes drop combinationally in the finish
  // cycle so the arbiter does not serve the same request twice.
  always_comb begin
    state_nxt = IDLE;
    req_ready = 1'b0;
    in_req    = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        state_nxt = req_valid ? REQ : IDLE;
      end
      REQ: begin
        in_req    = 1'b1;
        mem_read  = ~we_q & ~mem_finish;
        mem_write =  we_q & ~mem_finish;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        done      = mem_finish;
        // finish beats timeout when both land in the same cycle
        tmo       = ~mem_finish & (cnt == CNT_LAST);
        state_nxt = (done | tmo) ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches and saturating watchdog counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      cnt     <= '0;
    end else if (in_req && !mem_finish && cnt != '1) begin
      cnt     <= cnt + 1'b1;
    end
  end

  // Registered response; rdata holds until the next response.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= done | tmo;
      resp_err   <= tmo;
      if (done)     resp_rdata <= we_q ? '0 : mem_rdata;
      else if (tmo) resp_rdata <= '0;
    end
  end

  // Sticky flag for a finish arriving while no request is outstanding.
  always_ff @(posedge clock) begin
    if (reset) stray_fin <= 1'b0;
    else       stray_fin <= stray_fin | (mem_finish & ~in_req);
  end

endmodule

// File: tb/tb_core_mem_req_ctrl.sv
// Bench for core_mem_req_ctrl (TIMEOUT=4): vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_core_mem_req_ctrl;
  localparam int TO = 4;

  logic        clock = 0;
  logic        reset = 0;
  logic        req_valid = 0, req_ready, req_we = 0;
  logic [11:0] req_addr = 0;
  logic [7:0]  req_wdata = 0;
  logic        resp_valid, resp_err;
  logic [7:0]  resp_rdata;
  logic        mem_read, mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_finish = 0;
  logic [7:0]  mem_rdata = 0;
  logic        stray_fin;

  int total = 0;
  int bad   = 0;
  logic [7:0] last_rdata = 0;

  core_mem_req_ctrl #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_finish(mem_finish), .mem_rdata(mem_rdata),
    .stray_fin(stray_fin)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // lat = REQ cycle (1-based) carrying mem_finish, 0 = never
  // exp_off = cycles from accept to resp_valid, exp_strb = cycles with a strobe
  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  rdata;
    int          exp_off;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    int          exp_strb;
  } vec_t;

  vec_t vecs[6];

  task automatic run_row(input vec_t v);
    int resp_at = -1;
    int strobes = 0;
    @(posedge clock); #1;
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    mem_finish = 0; mem_rdata = 0;
    #1 chk("row_ready", req_ready, 1);
    for (int k = 1; k <= 20 && resp_at < 0; k++) begin
      @(posedge clock); #1;
      req_valid  = 0;
      mem_finish = (k == v.lat);
      mem_rdata  = (k == v.lat) ? v.rdata : 8'h00;
      #1;
      if (resp_valid) begin
        resp_at = k;
        chk("row_err", resp_err, v.exp_err);
        chk("row_rdata", resp_rdata, v.exp_rdata);
      end
      if (mem_read | mem_write) begin
        strobes++;
        chk("row_dir", mem_write, v.we);
        chk("row_addr", mem_addr, v.addr);
        chk("row_wdata", mem_wdata, v.wdata);
      end
    end
    mem_finish = 0;
    chk("row_resp_off", resp_at, v.exp_off);
    chk("row_strobes", strobes, v.exp_strb);
    last_rdata = v.exp_rdata;
  endtask

  initial begin
    bit         busy = 0, fin = 0, pend = 0, pend_err = 0;
    int         kk = 0, lat = 0, nresp = 0;
    logic       we_m = 0;
    logic [11:0] a_m = 0, ba[7];
    logic [7:0]  d_m = 0, pend_dat = 0, bd[7];

    vecs[0] = '{1'b0, 12'h3A5, 8'h00, 4, 8'h5C, 5, 1'b0, 8'h5C, 3}; // finish meets timeout
    vecs[1] = '{1'b1, 12'h010, 8'hA7, 2, 8'h00, 3, 1'b0, 8'h00, 1};
    vecs[2] = '{1'b0, 12'h7F0, 8'h11, 0, 8'h00, 5, 1'b1, 8'h00, 4}; // timeout
    vecs[3] = '{1'b1, 12'h123, 8'h5A, 1, 8'hEE, 2, 1'b0, 8'h00, 0}; // rdata ignored on store
    vecs[4] = '{1'b0, 12'hFFF, 8'h00, 3, 8'hFF, 4, 1'b0, 8'hFF, 2};
    vecs[5] = '{1'b1, 12'h800, 8'h3C, 0, 8'h00, 5, 1'b1, 8'h00, 4};

    // reset state
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stray", stray_fin, 0);
    reset = 0;

    // vector table
    for (int i = 0; i < 6; i++) run_row(vecs[i]);
    chk("table_no_stray", stray_fin, 0);

    // late finish after a timeout
    run_row(vecs[2]);
    mem_finish = 1;
    @(posedge clock); #1;
    mem_finish = 0;
    #1;
    chk("stray_set", stray_fin, 1);
    chk("stray_no_resp", resp_valid, 0);

    // reset while a load is outstanding
    @(posedge clock); #1;
    req_valid = 1; req_we = 0; req_addr = 12'h456; req_wdata = 0;
    @(posedge clock); #1;
    req_valid = 0;
    #1 chk("rstreq_read_before", mem_read, 1);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    #1;
    chk("rstreq_read", mem_read, 0);
    chk("rstreq_ready", req_ready, 1);
    chk("rstreq_resp", resp_valid, 0);
    chk("rstreq_stray_clr", stray_fin, 0);
    last_rdata = 0;
    repeat (3) begin
      @(posedge clock); #2;
      chk("rstreq_no_resp", resp_valid, 0);
      chk("rstreq_rdata", resp_rdata, 0);
    end

    // back-to-back loads, finish every 3rd cycle
    for (int i = 0; i < 7; i++) begin
      ba[i] = 12'($urandom);
      bd[i] = 8'($urandom);
    end
    req_we = 0;
    for (int c = 0; c <= 18; c++) begin
      @(posedge clock); #1;
      req_valid  = (c < 18);
      req_addr   = ba[c/3];
      req_wdata  = 8'($urandom);
      mem_finish = (c % 3 == 2);
      mem_rdata  = (c % 3 == 2) ? bd[c/3] : 8'h00;
      #1;
      chk("b2b_ready", req_ready, (c % 3 == 0));
      chk("b2b_resp", resp_valid, (c % 3 == 0 && c > 0));
      if (resp_valid) nresp++;
      if (c % 3 == 0 && c > 0) chk("b2b_rdata", resp_rdata, bd[c/3 - 1]);
      chk("b2b_addr", mem_addr, (c % 3 == 0) ? 12'h000 : ba[c/3]);
    end
    mem_finish = 0;
    chk("b2b_count", nresp, 6);
    last_rdata = bd[5];

    // randomized traffic against a transaction-level model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      fin        = busy && (kk == lat);
      mem_finish = fin;
      mem_rdata  = 8'($urandom);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = 1'($urandom);
      req_addr   = 12'($urandom);
      req_wdata  = 8'($urandom);
      #1;
      if (pend) last_rdata = pend_dat;
      chk("rnd_ready", req_ready, !busy);
      chk("rnd_resp_valid", resp_valid, pend);
      chk("rnd_resp_err", resp_err, pend & pend_err);
      chk("rnd_resp_rdata", resp_rdata, last_rdata);
      chk("rnd_read", mem_read, busy & !we_m & !fin);
      chk("rnd_write", mem_write, busy & we_m & !fin);
      chk("rnd_addr", mem_addr, busy ? a_m : 12'h000);
      chk("rnd_wdata", mem_wdata, busy ? d_m : 8'h00);
      chk("rnd_stray", stray_fin, 0);
      pend = 0;
      if (busy) begin
        if (fin) begin
          pend = 1; pend_err = 0; pend_dat = we_m ? 8'h00 : mem_rdata; busy = 0;
        end else if (kk == TO) begin
          pend = 1; pend_err = 1; pend_dat = 8'h00; busy = 0;
        end else begin
          kk++;
        end
      end else if (req_valid) begin
        busy = 1; kk = 1; lat = $urandom_range(1, 6);
        we_m = req_we; a_m = req_addr; d_m = req_wdata;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
